// File: rtl/branch_pred_gshare.sv
// Gshare branch predictor: multi-port lookup into one table of saturating counters indexed by
// PC XOR global history, with a post-reset initialisation sweep and weak-confidence flagging.
module branch_pred_gshare #(
    parameter int unsigned req_ports  = 3,
    parameter int unsigned table_size = 64,
    parameter int unsigned ctr_width  = 2,
    parameter int unsigned ghr_width  = 6,
    parameter int unsigned pc_width   = 32,
    parameter int unsigned pc_lsb     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    output logic                                 ready,
    input  logic [req_ports-1:0]                 req_valid,
    input  logic [req_ports-1:0][pc_width-1:0]   req_pc,
    output logic [req_ports-1:0]                 rsp_valid,
    output logic [req_ports-1:0]                 rsp_pred_taken,
    output logic [req_ports-1:0]                 rsp_exec_alt,
    output logic [req_ports-1:0][ghr_width-1:0]  rsp_ghr,
    input  logic                                 fb_valid,
    input  logic [pc_width-1:0]                  fb_pc,
    input  logic [ghr_width-1:0]                 fb_ghr,
    input  logic                                 fb_taken
);

    localparam int unsigned idx_w = (table_size > 1) ? $clog2(table_size) : 1;

    localparam logic [ctr_width-1:0] ctr_wnt  = ctr_width'((1 << (ctr_width - 1)) - 1);
    localparam logic [ctr_width-1:0] ctr_wt   = ctr_wnt + ctr_width'(1);
    localparam logic [ctr_width-1:0] ctr_max  = '1;
    localparam logic [idx_w-1:0]     idx_last = idx_w'(table_size - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    // The size cast truncates or zero-extends the history to the index width as needed.
    function automatic logic [idx_w-1:0] calc_idx(input logic [pc_width-1:0]  pc,
                                                  input logic [ghr_width-1:0] ghr);
        return pc[pc_lsb +: idx_w] ^ idx_w'(ghr);
    endfunction

    state_e                   state_q, state_d;
    logic [idx_w-1:0]         init_idx_q, init_idx_d;
    logic [ghr_width-1:0]     ghr_q, ghr_d, ghr_shift;
    logic [ctr_width-1:0]     table_q [table_size];

    logic                     lookup_en;
    logic                     fb_en;

    logic                     tbl_we;
    logic [idx_w-1:0]         tbl_waddr;
    logic [ctr_width-1:0]     tbl_wdata;

    logic [idx_w-1:0]         fb_idx;
    logic [ctr_width-1:0]     fb_ctr, fb_ctr_upd;

    logic [idx_w-1:0]         rd_idx [req_ports];
    logic [ctr_width-1:0]     rd_ctr [req_ports];

    logic [req_ports-1:0]                rsp_valid_q, rsp_valid_d;
    logic [req_ports-1:0]                rsp_pred_q, rsp_pred_d;
    logic [req_ports-1:0]                rsp_alt_q, rsp_alt_d;
    logic [req_ports-1:0][ghr_width-1:0] rsp_ghr_q, rsp_ghr_d;

    // PC bits outside the index window and history bits beyond idx_w do not affect the result.
    logic unused_bits;
    assign unused_bits = ^{req_pc, fb_pc, fb_ghr};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            StInit: begin
                init_idx_d = init_idx_q + idx_w'(1);
                if (init_idx_q == idx_last) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready     = (state_q == StReady);
        lookup_en = ready & en;
        fb_en     = lookup_en & fb_valid;
    end

    // ------------------------------------------------------------------
    // Feedback: saturating counter update and history shift
    // ------------------------------------------------------------------
    always_comb begin
        fb_idx     = calc_idx(fb_pc, fb_ghr);
        fb_ctr     = table_q[fb_idx];
        fb_ctr_upd = fb_ctr;
        if (fb_taken) begin
            if (fb_ctr != ctr_max) begin
                fb_ctr_upd = fb_ctr + ctr_width'(1);
            end
        end else begin
            if (fb_ctr != '0) begin
                fb_ctr_upd = fb_ctr - ctr_width'(1);
            end
        end
    end

    if (ghr_width == 1) begin : gen_ghr_single
        assign ghr_shift = fb_taken;
    end else begin : gen_ghr_shift
        assign ghr_shift = {ghr_q[ghr_width-2:0], fb_taken};
    end

    always_comb begin
        ghr_d = fb_en ? ghr_shift : ghr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // ------------------------------------------------------------------
    // Table write port: init sweep owns it until ready, then feedback does
    // ------------------------------------------------------------------
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = init_idx_q;
        tbl_wdata = ctr_wnt;
        if (!rst) begin
            if (state_q == StInit) begin
                tbl_we = 1'b1;
            end else if (fb_en) begin
                tbl_we    = 1'b1;
                tbl_waddr = fb_idx;
                tbl_wdata = fb_ctr_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Lookup ports: read pre-update table and live history, register result
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid_d = '0;
        rsp_pred_d  = rsp_pred_q;
        rsp_alt_d   = rsp_alt_q;
        rsp_ghr_d   = rsp_ghr_q;
        for (int unsigned p = 0; p < req_ports; p++) begin
            rd_idx[p] = calc_idx(req_pc[p], ghr_q);
            rd_ctr[p] = table_q[rd_idx[p]];
            rsp_valid_d[p] = lookup_en & req_valid[p];
            if (rsp_valid_d[p]) begin
                rsp_pred_d[p] = rd_ctr[p][ctr_width-1];
                rsp_alt_d[p]  = (rd_ctr[p] == ctr_wnt) || (rd_ctr[p] == ctr_wt);
                rsp_ghr_d[p]  = ghr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_pred_q  <= '0;
            rsp_alt_q   <= '0;
            rsp_ghr_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_pred_q  <= rsp_pred_d;
            rsp_alt_q   <= rsp_alt_d;
            rsp_ghr_q   <= rsp_ghr_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_pred_taken = rsp_pred_q;
    assign rsp_exec_alt   = rsp_alt_q;
    assign rsp_ghr        = rsp_ghr_q;

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Self-checking bench for branch_pred_gshare: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the predictor.
module tb_branch_pred_gshare;

    logic              clk;
    logic              rst;
    logic              en;
    logic              ready;
    logic [2:0]        req_valid;
    logic [2:0][31:0]  req_pc;
    logic [2:0]        rsp_valid;
    logic [2:0]        rsp_pred_taken;
    logic [2:0]        rsp_exec_alt;
    logic [2:0][5:0]   rsp_ghr;
    logic              fb_valid;
    logic [31:0]       fb_pc;
    logic [5:0]        fb_ghr;
    logic              fb_taken;

    int n_checks;
    int n_fail;

    // Behavioural model state
    int mtbl [64];
    int mghr;
    int minit;
    bit mready;
    bit exp_valid [3];
    bit exp_pred [3];
    bit exp_alt [3];
    int exp_ghr [3];

    branch_pred_gshare #(
        .req_ports (3),
        .table_size(64),
        .ctr_width (2),
        .ghr_width (6),
        .pc_width  (32),
        .pc_lsb    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .ready         (ready),
        .req_valid     (req_valid),
        .req_pc        (req_pc),
        .rsp_valid     (rsp_valid),
        .rsp_pred_taken(rsp_pred_taken),
        .rsp_exec_alt  (rsp_exec_alt),
        .rsp_ghr       (rsp_ghr),
        .fb_valid      (fb_valid),
        .fb_pc         (fb_pc),
        .fb_ghr        (fb_ghr),
        .fb_taken      (fb_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int midx(input longint unsigned pc, input int g);
        return int'((pc / 4) % 64) ^ (g % 64);
    endfunction

    // Advance the model by one clock with the currently driven inputs, then step the DUT.
    task automatic tick();
        if (rst) begin
            mghr = 0;
            minit = 0;
            mready = 0;
            for (int p = 0; p < 3; p++) begin
                exp_valid[p] = 0; exp_pred[p] = 0; exp_alt[p] = 0; exp_ghr[p] = 0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (mready && en && req_valid[p]) begin
                    int c;
                    c = mtbl[midx(req_pc[p], mghr)];
                    exp_valid[p] = 1;
                    exp_pred[p]  = (c >= 2);
                    exp_alt[p]   = (c == 1) || (c == 2);
                    exp_ghr[p]   = mghr;
                end else begin
                    exp_valid[p] = 0;
                end
            end
            if (mready && en && fb_valid) begin
                int i;
                i = midx(fb_pc, int'(fb_ghr));
                if (fb_taken) mtbl[i] = (mtbl[i] < 3) ? mtbl[i] + 1 : 3;
                else          mtbl[i] = (mtbl[i] > 0) ? mtbl[i] - 1 : 0;
                mghr = (mghr * 2 + (fb_taken ? 1 : 0)) % 64;
            end
            if (!mready) begin
                minit++;
                if (minit == 64) begin
                    mready = 1;
                    for (int i = 0; i < 64; i++) mtbl[i] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1; rst = 1; fb_valid = 0; fb_taken = 0; fb_pc = 0; fb_ghr = 0;
        req_valid = 3'b001; req_pc[0] = 32'h100; req_pc[1] = 0; req_pc[2] = 0;
        tick();
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_checks++;
        if (rsp_valid !== 3'b000) begin
            n_fail++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid);
        end
        rst = 0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            n_checks++;
            if (ready !== (c == 64)) begin
                n_fail++; $display("FAIL init_ready cycle %0d got %b want %b", c, ready, c == 64);
            end
            n_checks++;
            if (rsp_valid !== 3'b000) begin
                n_fail++; $display("FAIL init_rsp_valid cycle %0d got %b want 000", c, rsp_valid);
            end
        end
        req_valid = 0;
    endtask

    task automatic test_fresh_lookup();
        req_valid = 3'b001; req_pc[0] = 32'h100;
        tick();
        req_valid = 0;
        n_checks++;
        if (rsp_valid !== 3'b001) begin
            n_fail++; $display("FAIL fresh_valid got %b want 001", rsp_valid);
        end
        n_checks++;
        if ({rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL fresh_fields got pred %b alt %b ghr %0d want pred 0 alt 1 ghr 0",
                     rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
    endtask

    task automatic test_training();
        fb_valid = 1; fb_pc = 32'h10C; fb_ghr = 0; fb_taken = 1;
        tick();
        tick();
        fb_valid = 0;
        req_valid = 3'b111;
        for (int p = 0; p < 3; p++) req_pc[p] = 32'h100;
        tick();
        req_valid = 0;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if ({rsp_valid[p], rsp_pred_taken[p], rsp_exec_alt[p], rsp_ghr[p]}
                    !== {1'b1, 1'b1, 1'b0, 6'd3}) begin
                n_fail++;
                $display("FAIL train_port%0d got v %b pred %b alt %b ghr %0d want v 1 pred 1 alt 0 ghr 3",
                         p, rsp_valid[p], rsp_pred_taken[p], rsp_exec_alt[p], rsp_ghr[p]);
            end
        end
    endtask

    task automatic test_saturation();
        fb_valid = 1; fb_pc = 32'h28; fb_ghr = 0; fb_taken = 1;
        repeat (5) tick();
        fb_valid = 0;
        req_valid = 3'b001; req_pc[0] = 32'((10 ^ mghr) * 4);
        tick();
        n_checks++;
        if ({rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]} !== {1'b1, 1'b0, 6'd63}) begin
            n_fail++;
            $display("FAIL sat_high got pred %b alt %b ghr %0d want pred 1 alt 0 ghr 63",
                     rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
        req_valid = 0;
        fb_valid = 1; fb_taken = 0;
        repeat (5) tick();
        fb_valid = 0;
        req_valid = 3'b001; req_pc[0] = 32'((10 ^ mghr) * 4);
        tick();
        req_valid = 0;
        n_checks++;
        if ({rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]} !== {1'b0, 1'b0, 6'd32}) begin
            n_fail++;
            $display("FAIL sat_low got pred %b alt %b ghr %0d want pred 0 alt 0 ghr 32",
                     rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
    endtask

    task automatic test_back_to_back();
        // Entry 20 is still at its initial weak-not-taken value; history is 32 here.
        fb_valid = 1; fb_pc = 32'h50; fb_ghr = 0; fb_taken = 1;
        req_valid = 3'b001; req_pc[0] = 32'((20 ^ 32) * 4);
        tick();
        n_checks++;
        if ({rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]} !== {1'b0, 1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL hazard_same got pred %b alt %b ghr %0d want pred 0 alt 1 ghr 32",
                     rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
        fb_valid = 0;
        req_pc[0] = 32'((20 ^ 1) * 4);
        tick();
        req_valid = 0;
        n_checks++;
        if ({rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]} !== {1'b1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL hazard_next got pred %b alt %b ghr %0d want pred 1 alt 1 ghr 1",
                     rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
    endtask

    task automatic test_enable();
        en = 0;
        fb_valid = 1; fb_pc = 32'h50; fb_ghr = 0; fb_taken = 1;
        req_valid = 3'b111;
        for (int p = 0; p < 3; p++) req_pc[p] = 32'd84;
        tick();
        n_checks++;
        if ({ready, rsp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL en_off got ready %b valid %b want ready 1 valid 000", ready, rsp_valid);
        end
        en = 1; fb_valid = 0; req_valid = 3'b001;
        tick();
        req_valid = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]}
                !== {1'b1, 1'b1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL en_unchanged got v %b pred %b alt %b ghr %0d want v 1 pred 1 alt 1 ghr 1",
                     rsp_valid[0], rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1; req_valid = 3'b001; req_pc[0] = 32'd84;
        tick();
        n_checks++;
        if ({ready, rsp_valid, rsp_pred_taken, rsp_exec_alt, rsp_ghr} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got ready %b v %b pred %b alt %b ghr %h want all 0",
                     ready, rsp_valid, rsp_pred_taken, rsp_exec_alt, rsp_ghr);
        end
        rst = 0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 3'b000) begin
                n_fail++; $display("FAIL midrst_init_valid cycle %0d got %b want 000", c, rsp_valid);
            end
        end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", ready); end
        req_pc[0] = 32'h10C;
        tick();
        req_valid = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]}
                !== {1'b1, 1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL midrst_retrained got v %b pred %b alt %b ghr %0d want v 1 pred 0 alt 1 ghr 0",
                     rsp_valid[0], rsp_pred_taken[0], rsp_exec_alt[0], rsp_ghr[0]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            en = ($urandom_range(0, 7) != 0);
            req_valid = 3'($urandom);
            for (int p = 0; p < 3; p++) begin
                req_pc[p] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            fb_valid = 1'($urandom_range(0, 1));
            fb_pc    = 32'($urandom_range(0, 255));
            fb_ghr   = ($urandom_range(0, 1) == 1) ? 6'(mghr) : 6'($urandom);
            fb_taken = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (ready !== mready) begin
                n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, ready, mready);
            end
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if ({rsp_valid[p], rsp_pred_taken[p], rsp_exec_alt[p], rsp_ghr[p]}
                        !== {exp_valid[p], exp_pred[p], exp_alt[p], 6'(exp_ghr[p])}) begin
                    n_fail++;
                    $display("FAIL rand_port%0d cyc %0d got v %b pred %b alt %b ghr %0d want v %b pred %b alt %b ghr %0d",
                             p, cyc, rsp_valid[p], rsp_pred_taken[p], rsp_exec_alt[p], rsp_ghr[p],
                             exp_valid[p], exp_pred[p], exp_alt[p], exp_ghr[p]);
                end
            end
        end
        en = 1; req_valid = 0; fb_valid = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        mghr = 0; minit = 0; mready = 0;
        for (int i = 0; i < 64; i++) mtbl[i] = 1;
        test_reset();
        test_fresh_lookup();
        test_training();
        test_saturation();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
